// File: rtl/mem_loader_pkg.sv
// Shared frame layout and loader state encoding for the operand-memory writer.
package mem_loader_pkg;

  localparam int N_INPUT     = 16;
  localparam int N_FILTER    = 9;
  localparam int FRAME_LEN   = N_INPUT + N_FILTER;
  localparam int FILTER_BASE = N_INPUT;
  localparam int ADDR_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CSUM = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_loader.sv
// Byte-stream frame loader: writes 25 operand words to memory, then checks
// the trailing modulo-256 checksum byte and reports the verdict.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              chk_ok
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [4:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                chk_ok_q, chk_ok_d;
  logic                accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    chk_ok_d  = chk_ok_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          sum_d    = '0;
          chk_ok_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = in_data;
          sum_d     = sum_q + in_data;
          // Counter parks on the last address rather than running past it.
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_CSUM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          chk_ok_d = (in_data == sum_q);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are decoded from the next state so they appear registered.
    in_ready_d = (state_d == ST_LOAD) || (state_d == ST_CSUM);
    busy_d     = in_ready_d;
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      chk_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      chk_ok_q   <= chk_ok_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign chk_ok   = chk_ok_q;

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Writer side of the operand memory: accepts a byte stream and produces write strobes that fill the 16 input-feature registers and the 9 filter registers. The memory block reads those registers out to the PE, 3x3 and 2x2 systolic arrays.
- Sits between an external byte source (host or UART front end) and the memory write port.
- Frame format: 25 data bytes followed by 1 checksum byte. Reports completion and a checksum verdict to the controller.

Parameters:
- DATA_W, 8, byte width of stream and write data
- N_INPUT, 16, number of input-feature words (4x4, row-major i00..i33)
- N_FILTER, 9, number of filter words (3x3, row-major f00..f22)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin loading a frame
- in_valid  in  1  source has a byte on in_data
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  write strobe to memory
- wr_addr  out  5  0..15 = input_data0..15, 16..24 = filter_data0..8
- wr_data  out  DATA_W  write data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of frame
- chk_ok  out  1  checksum verdict of last frame, held

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, address counter 0, running sum 0.
- Transfer rule: a byte is accepted only when in_valid and in_ready are both high on a rising edge.
- in_ready is a registered state decode: 1 in LOAD and CSUM, 0 elsewhere. It never depends combinationally on in_valid.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD. Clear address counter and sum, clear chk_ok, set busy.
- LOAD:
  - Each accepted byte produces a write on the next cycle: wr_en=1, wr_addr=counter, wr_data=byte. Latency is exactly 1 cycle.
  - Then the counter increments and sum += byte (mod 2^DATA_W).
  - Accepting the byte at counter = N_INPUT+N_FILTER-1 (24) -> CSUM.
  - Cycles with in_valid=0 produce no write, and counter and sum hold.
- CSUM:
  - The next accepted byte is compared with the running sum and is not written (wr_en=0).
  - chk_ok <= (byte == sum). Go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, in_ready=0, then IDLE.
  - chk_ok holds until the next start.
- wr_en is 0 in every cycle that does not follow an accepted LOAD byte. wr_addr and wr_data hold their last value when wr_en=0.
- start is ignored in LOAD, CSUM and DONE.
- start together with rst: rst wins.
- Reset mid-frame: returns to IDLE on the next edge. Memory contents already written stay as they are; that is not this block's concern. The next start restarts at address 0.
- The counter never exceeds 24, so there is no wrap-around. Sum arithmetic is modulo 256.

Decomposition:
- Shared package:
  - state encoding (IDLE, LOAD, CSUM, DONE)
  - N_INPUT, N_FILTER, FRAME_LEN = N_INPUT+N_FILTER
  - filter base address = N_INPUT
- No sub-module is needed. The FSM, counter and checksum accumulator live in one module.

Test Plan:
- Basic load: start, then bytes 1..25 back-to-back, then checksum 0x45 (325 mod 256).
  - 25 writes with wr_addr 0..24 and wr_data 1..25, each one cycle after its acceptance.
  - done pulses once, chk_ok=1.
- Bad checksum: same frame with checksum 0x00 -> all 25 writes occur, done pulses, chk_ok=0.
- Gapped source: in_valid toggles 1,0,0,1,... over a frame of all 0xFF, checksum 0xE7 (25*255 mod 256).
  - Writes occur only after accepted bytes, no duplicated or skipped addresses, chk_ok=1.
- start ignored while busy: pulse start during byte 10 -> counter continues at 11 and the frame completes normally.
- Reset mid-frame: assert rst after byte 12.
  - Next cycle all outputs are 0 and state is IDLE.
  - A new start followed by bytes 0xA0.. writes from address 0.
- Idle stream: in_valid=1 in IDLE with no start -> in_ready=0 and no wr_en for 20 cycles.
